// File: rtl/acq_mem_if.sv
// Capture buffer write port between the acquisition sequencer and its RAM.
interface acq_mem_if #(
  parameter int ADDR_W = 13,
  parameter int MEM_W  = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic              mem_wen;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wen
  );

  modport slave (
    input mem_addr,
    input mem_wdata,
    input mem_wen
  );
endinterface

// File: rtl/acq_sequencer.sv
// Multi-shot pulser/ADC capture sequencer: fires pulse windows, decimates
// samples and streams them into a wrapping capture buffer.
module acq_sequencer #(
  parameter int ADC_W  = 10,
  parameter int ADDR_W = 13,
  parameter int MEM_W  = 16,
  parameter int SHOT_W = 4
) (
  input  logic              DCLK,
  input  logic              rst,
  input  logic              trig,
  input  logic              abort,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [7:0]        cfg_phv_start,
  input  logic [7:0]        cfg_pnhv_start,
  input  logic [7:0]        cfg_damp_start,
  input  logic [7:0]        cfg_phv_len,
  input  logic [7:0]        cfg_pnhv_len,
  input  logic [7:0]        cfg_damp_len,
  input  logic [ADDR_W-1:0] cfg_depth,
  input  logic [1:0]        cfg_dec,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic [15:0]       cfg_gap,
  output logic              PHV,
  output logic              PnHV,
  output logic              Pdamp,
  acq_mem_if.master         mem,
  output logic              busy,
  output logic              done,
  output logic [SHOT_W-1:0] shot_idx,
  output logic              wrapped
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int AW = ADC_W + 3;
  localparam int TW = (ADDR_W + 4 > 10) ? ADDR_W + 4 : 10;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              bcry_q, bcry_d;
  logic              last_q, last_d;
  logic [15:0]       gcnt_q, gcnt_d;

  logic [7:0]        phs_q, phs_d, phl_q, phl_d;
  logic [7:0]        pns_q, pns_d, pnl_q, pnl_d;
  logic [7:0]        dms_q, dms_d, dml_q, dml_d;
  logic [ADDR_W-1:0] depth_q, depth_d;
  logic [1:0]        dec_q, dec_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [15:0]       gap_q, gap_d;

  logic              phv_q, phv_d, pnhv_q, pnhv_d;
  logic              pdmp_q, pdmp_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_W-1:0]  wdat_q, wdat_d;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic              wrap_q, wrap_d;

  logic [2:0]        dmask;
  logic              fin;
  logic              cplt;
  logic [AW-1:0]     sum;
  logic [ADDR_W:0]   asum;
  logic [ADDR_W:0]   bsum;
  logic              w_ph, w_pn, w_dm;

  function automatic logic in_win(
    input logic [TW-1:0] t,
    input logic [7:0]    s,
    input logic [7:0]    l
  );
    logic [8:0] e;
    e = {1'b0, s} + {1'b0, l};
    return (l != 8'd0) && (t >= TW'(s)) && (t < TW'(e));
  endfunction

  assign dmask = 3'((4'd1 << dec_q) - 4'd1);
  // The final write of a shot occupies one extra CAPT cycle.
  assign fin   = (state_q == S_CAPT) && wen_q && last_q;
  assign cplt  = (state_q == S_CAPT) && !fin &&
                 ((t_q[2:0] & dmask) == dmask);
  assign sum   = acc_q + AW'(adc_data);
  assign asum  = {1'b0, base_q} + {1'b0, widx_q};
  assign bsum  = {1'b0, base_q} + {1'b0, depth_q} + 1'b1;
  assign w_ph  = in_win(t_q, phs_q, phl_q);
  assign w_pn  = in_win(t_q, pns_q, pnl_q);
  assign w_dm  = in_win(t_q, dms_q, dml_q);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    acc_d   = acc_q;
    widx_d  = widx_q;
    base_d  = base_q;
    bcry_d  = bcry_q;
    last_d  = last_q;
    gcnt_d  = gcnt_q;
    phs_d   = phs_q;
    phl_d   = phl_q;
    pns_d   = pns_q;
    pnl_d   = pnl_q;
    dms_d   = dms_q;
    dml_d   = dml_q;
    depth_d = depth_q;
    dec_d   = dec_q;
    shots_d = shots_q;
    gap_d   = gap_q;
    phv_d   = 1'b0;
    pnhv_d  = 1'b0;
    pdmp_d  = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    shot_d  = shot_q;
    wrap_d  = wrap_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_d = S_CAPT;
            phs_d   = cfg_phv_start;
            phl_d   = cfg_phv_len;
            pns_d   = cfg_pnhv_start;
            pnl_d   = cfg_pnhv_len;
            dms_d   = cfg_damp_start;
            dml_d   = cfg_damp_len;
            depth_d = cfg_depth;
            dec_d   = cfg_dec;
            shots_d = cfg_shots;
            gap_d   = cfg_gap;
            t_d     = '0;
            acc_d   = '0;
            widx_d  = '0;
            base_d  = '0;
            bcry_d  = 1'b0;
            last_d  = 1'b0;
            shot_d  = '0;
            wrap_d  = 1'b0;
          end
        end
        S_CAPT: begin
          t_d    = t_q + 1'b1;
          phv_d  = !fin && w_ph && !w_pn;
          pnhv_d = !fin && w_pn && !w_ph;
          pdmp_d = !fin && w_dm;
          acc_d  = sum;
          if (cplt) begin
            wen_d  = 1'b1;
            acc_d  = '0;
            wdat_d = MEM_W'(sum);
            addr_d = asum[ADDR_W-1:0];
            widx_d = widx_q + 1'b1;
            last_d = (widx_q == depth_q);
            wrap_d = wrap_q | asum[ADDR_W] | bcry_q;
          end
          if (fin) begin
            t_d    = '0;
            acc_d  = '0;
            widx_d = '0;
            last_d = 1'b0;
            gcnt_d = '0;
            if (shot_q == shots_q) begin
              state_d = S_DONE;
            end else begin
              shot_d  = shot_q + 1'b1;
              base_d  = bsum[ADDR_W-1:0];
              bcry_d  = bcry_q | bsum[ADDR_W];
              state_d = (gap_q == 16'd0) ? S_CAPT : S_GAP;
            end
          end
        end
        S_GAP: begin
          gcnt_d = gcnt_q + 16'd1;
          if (gcnt_q == gap_q - 16'd1) begin
            gcnt_d  = '0;
            state_d = S_CAPT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge DCLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      acc_q   <= '0;
      widx_q  <= '0;
      base_q  <= '0;
      bcry_q  <= 1'b0;
      last_q  <= 1'b0;
      gcnt_q  <= '0;
      phs_q   <= '0;
      phl_q   <= '0;
      pns_q   <= '0;
      pnl_q   <= '0;
      dms_q   <= '0;
      dml_q   <= '0;
      depth_q <= '0;
      dec_q   <= '0;
      shots_q <= '0;
      gap_q   <= '0;
      phv_q   <= 1'b0;
      pnhv_q  <= 1'b0;
      pdmp_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      shot_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      widx_q  <= widx_d;
      base_q  <= base_d;
      bcry_q  <= bcry_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
      phs_q   <= phs_d;
      phl_q   <= phl_d;
      pns_q   <= pns_d;
      pnl_q   <= pnl_d;
      dms_q   <= dms_d;
      dml_q   <= dml_d;
      depth_q <= depth_d;
      dec_q   <= dec_d;
      shots_q <= shots_d;
      gap_q   <= gap_d;
      phv_q   <= phv_d;
      pnhv_q  <= pnhv_d;
      pdmp_q  <= pdmp_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      shot_q  <= shot_d;
      wrap_q  <= wrap_d;
    end
  end

  assign PHV           = phv_q;
  assign PnHV          = pnhv_q;
  assign Pdamp         = pdmp_q;
  assign mem.mem_wen   = wen_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdat_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign shot_idx      = shot_q;
  assign wrapped       = wrap_q;

endmodule
